// File: rtl/display_scan.sv
// Multiplexed 8-digit display scanner with a write-back digit buffer and an inter-slot blanking gap.
// Define DISPLAY_SCAN_BLANK_EN to enable leading-zero suppression of the shown code.
module display_scan #(
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iWrEn,
  input  logic [2:0] iWrAddr,
  input  logic [3:0] iWrData,
  input  logic       iClr,
  output logic [3:0] oDigit,
  output logic [7:0] oAnode,
  output logic       oFrame
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // One extra bit so that a zero-length gap (SHOW_LEN == CLK_DIV) still fits.
  localparam logic [CNT_W:0] SHOW_LEN = (CNT_W + 1)'(CLK_DIV - GAP_CYCLES);

  localparam logic [0:0] ST_SHOW = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             wrapped;
  logic [7:0][3:0]  dbuf;
  logic             wr_vld_p0;
  logic [2:0]       wr_addr_p0;
  logic [3:0]       wr_data_p0;
  logic [0:0]       state;
  logic [3:0]       disp_code;

`ifdef DISPLAY_SCAN_BLANK_EN
  function automatic logic [3:0] blank_lead(input logic [7:0][3:0] b, input logic [2:0] sel);
    logic lead;
    lead = 1'b1;
    for (int j = 1; j < 8; j++) begin
      if (j > int'(sel) && b[j] != 4'h0 && b[j] != 4'hF) lead = 1'b0;
    end
    return (sel != 3'd0 && b[sel] == 4'h0 && lead) ? 4'hF : b[sel];
  endfunction
`endif

  always_comb begin
    state = ({1'b0, cnt} < SHOW_LEN) ? ST_SHOW : ST_GAP;
  end

  always_comb begin
`ifdef DISPLAY_SCAN_BLANK_EN
    disp_code = blank_lead(dbuf, idx);
`else
    disp_code = dbuf[idx];
`endif
  end

  // Stage p0: write request captured, committed to the buffer one edge later
  always_ff @(posedge iClk) begin
    wr_addr_p0 <= iWrAddr;
    wr_data_p0 <= iWrData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt       <= '0;
      idx       <= 3'd0;
      wrapped   <= 1'b0;
      wr_vld_p0 <= 1'b0;
      dbuf      <= {8{4'hF}};
      oAnode    <= 8'hFF;
      oDigit    <= 4'hF;
      oFrame    <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
        if (idx == 3'd7) wrapped <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // A clear wins over both the incoming and the already-captured write.
      wr_vld_p0 <= iWrEn & ~iClr;
      if (iClr) begin
        dbuf <= {8{4'hF}};
      end else if (wr_vld_p0) begin
        dbuf[wr_addr_p0] <= wr_data_p0;
      end

      if (state == ST_SHOW) begin
        oAnode <= ~(8'h01 << idx);
        oDigit <= disp_code;
      end else begin
        oAnode <= 8'hFF;
        oDigit <= 4'hF;
      end
      oFrame <= wrapped && (cnt == '0) && (idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan (CLK_DIV=8, GAP_CYCLES=2) against an event-log reference model.
module tb_display_scan;

  localparam int CLK_DIV = 8;
  localparam int GAP     = 2;
  localparam int SLOT    = CLK_DIV;
  localparam int FRAME   = 8 * CLK_DIV;

  logic       iClk;
  logic       iRst;
  logic       iWrEn;
  logic [2:0] iWrAddr;
  logic [3:0] iWrData;
  logic       iClr;
  logic [3:0] oDigit;
  logic [7:0] oAnode;
  logic       oFrame;

  display_scan #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .iClk(iClk), .iRst(iRst), .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .iClr(iClr), .oDigit(oDigit), .oAnode(oAnode), .oFrame(oFrame)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    int         t;
    bit         clr;
    logic [2:0] a;
    logic [3:0] d;
  } ev_t;

  ev_t        evq[$];
  int         ecnt = 0;
  int         pos = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_anode;
  logic [3:0] exp_digit;
  logic       exp_frame;

  // Buffer entry as seen by the output produced at edge k: clears show up
  // one edge after being sampled, writes two edges after.
  function automatic logic [3:0] mdl_entry(int e, int k);
    logic [3:0] v;
    v = 4'hF;
    foreach (evq[i]) begin
      if (evq[i].clr && evq[i].t <= k - 1) v = 4'hF;
      else if (!evq[i].clr && int'(evq[i].a) == e && evq[i].t <= k - 2) v = evq[i].d;
    end
    return v;
  endfunction

  function automatic logic [3:0] mdl_digit(int ix, int k);
    logic [3:0] vals [8];
    int top;
    for (int e = 0; e < 8; e++) vals[e] = mdl_entry(e, k);
    top = 0;
    for (int e = 0; e < 8; e++) if (vals[e] != 4'h0 && vals[e] != 4'hF) top = e;
`ifdef DISPLAY_SCAN_BLANK_EN
    if (ix != 0 && ix > top && vals[ix] == 4'h0) return 4'hF;
`endif
    return vals[ix];
  endfunction

  task automatic step(input logic rst, input logic en, input logic [2:0] a,
                      input logic [3:0] d, input logic clr);
    int k, c, ix;
    iRst = rst; iWrEn = en; iWrAddr = a; iWrData = d; iClr = clr;
    @(posedge iClk);
    k = ecnt;
    if (rst) begin
      exp_anode = 8'hFF; exp_digit = 4'hF; exp_frame = 1'b0;
      evq.delete();
      pos = 0;
    end else begin
      c  = pos % SLOT;
      ix = (pos / SLOT) % 8;
      exp_anode = (c < SLOT - GAP) ? ~(8'h01 << ix) : 8'hFF;
      exp_digit = (c < SLOT - GAP) ? mdl_digit(ix, k) : 4'hF;
      exp_frame = (pos >= FRAME) && (pos % FRAME == 0);
      if (clr) evq.push_back('{k, 1'b1, 3'd0, 4'd0});
      else if (en) evq.push_back('{k, 1'b0, a, d});
      pos++;
    end
    ecnt++;
    #1;
  endtask

  task automatic idle_to(int m, int modulo);
    for (int i = 0; i < 200 && (pos % modulo) != m; i++) step(0, 0, 3'd0, 4'd0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 1), 3'd0, 4'h3, 0);
      n_cmp++;
      if (oAnode !== 8'hFF || oDigit !== 4'hF || oFrame !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: anode=%h digit=%h frame=%b, want anode=ff digit=f frame=0", oAnode, oDigit, oFrame);
      end
    end
  endtask

  task automatic test_empty_scan();
    int first;
    first = -1;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      if (oFrame === 1'b1 && first < 0) first = i + 1;
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL empty_scan t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
    n_cmp++;
    if (first != 65) begin
      n_bad++;
      $display("FAIL first_frame_cycle: got %0d, want 65", first);
    end
  endtask

  task automatic test_fill_frame();
    for (int a = 0; a < 8; a++) begin
      step(0, 1, 3'(a), 4'(a + 1), 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL fill_write t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
    for (int i = 0; i < FRAME + 4; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL fill_frame t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  task automatic test_live_rewrite();
    idle_to(3, FRAME);
    step(0, 1, 3'd0, 4'h9, 0);
    step(0, 0, 3'd0, 4'd0, 0);
    n_cmp++;
    if (oAnode !== 8'hFE || oDigit !== 4'h1) begin
      n_bad++;
      $display("FAIL rewrite_hold: got %h/%h, want fe/1", oAnode, oDigit);
    end
    step(0, 0, 3'd0, 4'd0, 0);
    n_cmp++;
    if (oAnode !== 8'hFE || oDigit !== 4'h9) begin
      n_bad++;
      $display("FAIL rewrite_show: got %h/%h, want fe/9", oAnode, oDigit);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL rewrite_after t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  task automatic test_slot_advance_write();
    logic [2:0] nxt;
    idle_to(SLOT - 1, SLOT);
    nxt = 3'(((pos / SLOT) + 1) % 8);
    step(0, 1, nxt, 4'hD, 0);
    step(0, 0, 3'd0, 4'd0, 0);
    step(0, 0, 3'd0, 4'd0, 0);
    n_cmp++;
    if (oAnode !== ~(8'h01 << nxt) || oDigit !== 4'hD) begin
      n_bad++;
      $display("FAIL advance_write: got %h/%h, want %h/d", oAnode, oDigit, ~(8'h01 << nxt));
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL advance_after t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  task automatic test_clear_collision();
    int non_f;
    non_f = 0;
    step(0, 1, 3'd3, 4'h5, 1);
    for (int i = 0; i < FRAME + 2; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      if (oDigit !== 4'hF) non_f++;
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL clear_frame t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
    n_cmp++;
    if (non_f != 0) begin
      n_bad++;
      $display("FAIL clear_all_f: non-F digits=%0d, want 0", non_f);
    end
  endtask

  task automatic test_reset_mid_slot();
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), 4'(8 - a), 0);
    idle_to(5 * SLOT + 4, FRAME);
    step(1, 1, 3'd5, 4'h7, 0);
    n_cmp++;
    if (oAnode !== 8'hFF || oDigit !== 4'hF || oFrame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h/%h/%b, want ff/f/0", oAnode, oDigit, oFrame);
    end
    step(0, 0, 3'd0, 4'd0, 0);
    n_cmp++;
    if (oAnode !== 8'hFE || oDigit !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_restart: got %h/%h, want fe/f", oAnode, oDigit);
    end
    for (int i = 0; i < 2 * SLOT; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL reset_after t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  task automatic test_blank_pattern();
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), (a == 2) ? 4'h1 : 4'h0, 0);
    for (int i = 0; i < FRAME + 4; i++) begin
      step(0, 0, 3'd0, 4'd0, 0);
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL blank_pattern t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      step(r < 1, (r >= 4 && r < 40), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), (r >= 1 && r < 4));
      n_cmp++;
      if (oAnode !== exp_anode || oDigit !== exp_digit || oFrame !== exp_frame) begin
        n_bad++;
        $display("FAIL random t=%0d: got %h/%h/%b, want %h/%h/%b", ecnt, oAnode, oDigit, oFrame, exp_anode, exp_digit, exp_frame);
      end
    end
  endtask

  initial begin
    iRst = 1'b1; iWrEn = 1'b0; iWrAddr = 3'd0; iWrData = 4'd0; iClr = 1'b0;
    test_reset();
    test_empty_scan();
    test_fill_frame();
    test_live_rewrite();
    test_slot_advance_write();
    test_clear_collision();
    test_reset_mid_slot();
    test_blank_pattern();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
